ram_sdp_param: RTL and testbench
================================

Name: ram_sdp_param

Overview:
- Parametrised, technology-independent simple-dual-port RAM. Next generation of the team's SDP memory wrappers.
- One write port with a per-bit write mask, one read port.
- Configurable read latency (1 or 2) and optional read-during-write bypass.
- Optional zero-fill of the array after reset via an init state machine.
- Defined out-of-range handling with a sticky error flag. Sits under the instruction/data memory hierarchy wherever a hard macro is unavailable or unsuitable.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from rden to q/q_valid; legal values 1 or 2. Other values are a elaboration error.
- BYPASS, 1, 1 = same-cycle same-address read returns the newly written data; 0 = returns old data.
- CLEAR_ON_RESET, 1, 1 = zero-fill all DEPTH words after reset; 0 = contents undefined, no init phase.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data  in  DATA_WIDTH  write data.
- wraddress  in  ADDR_WIDTH  write address.
- wrmask  in  DATA_WIDTH  per-bit write enable, 1 = bit written.
- wren  in  1  write request.
- rdaddress  in  ADDR_WIDTH  read address.
- rden  in  1  read request.
- q  out  DATA_WIDTH  read data.
- q_valid  out  1  one-cycle pulse, q carries the data for a read.
- busy  out  1  high while init is in progress; requests are ignored.
- wr_error  out  1  sticky, set by an out-of-range write.

Behaviour:
- Interface: one clock named clock; reset is synchronous and active-high, named reset.
- Reset cycle: q=0, q_valid=0, wr_error=0, read pipeline flushed, FSM -> INIT (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0). During reset, busy = CLEAR_ON_RESET.
- FSM INIT:
  - Counter starts at 0. Writes all-zero to word counter each cycle. Counter increments.
  - The cycle that writes word DEPTH-1 is the last INIT cycle; next state is RUN.
  - INIT lasts exactly DEPTH cycles after reset deasserts. busy=1 throughout INIT and 0 in RUN.
  - wren/rden are ignored in INIT: no array write, no q_valid, no wr_error update.
- Reset asserted mid-INIT restarts INIT at word 0.
- Reset asserted in RUN discards in-flight reads (no q_valid) but does not clear the array unless CLEAR_ON_RESET=1.
- FSM RUN is terminal until reset.
- Write (RUN, wren=1, wraddress<DEPTH): mem[a] <= (mem[a] & ~wrmask) | (data & wrmask). wrmask=0 is a legal no-op write.
- Out-of-range write (wraddress>=DEPTH):
  - The write is dropped; no clamping or aliasing.
  - wr_error <= 1 and holds until reset.
  - Simultaneous reset wins.
- Read (RUN, rden=1):
  - Address sampled at the request edge.
  - q and q_valid appear READ_LATENCY cycles later; q_valid is high for exactly one cycle per request.
  - Back-to-back reads every cycle are supported at full throughput.
  - The READ_LATENCY=2 output register adds one stage and is fully pipelined.
- Out-of-range read (rdaddress>=DEPTH): q=0 with q_valid=1; wr_error is unaffected.
- q holds its last value when no read completes; it is not zeroed between reads.
- Same-cycle wren and rden to the same in-range address:
  - BYPASS=1: read returns the merged post-write word.
  - BYPASS=0: read returns the pre-write word.
- A read issued the cycle after a write to the same address always returns the new data, for either BYPASS setting.
- Simultaneous wren and rden to different addresses are fully independent.
- X on data/wrmask with wren=0 must not corrupt the array.

Test Plan:
- DEPTH=256, CLEAR_ON_RESET=1: pulse reset, then rden to address 0x05 during INIT -> busy high for exactly 256 cycles, no q_valid; after busy falls, read 0xFF -> q=0x00000000, q_valid 1 cycle later (READ_LATENCY=1).
- Write 0xDEADBEEF to 0x10 with wrmask 0xFFFFFFFF, then 0x12345678 with wrmask 0x0000FFFF -> read 0x10 gives 0xDEAD5678.
- BYPASS=1, then BYPASS=0: same cycle wren=1 and rden=1 to 0x20 (old 0x11111111, new 0x22222222) -> q=0x22222222 / 0x11111111 respectively; read on the following cycle gives 0x22222222 in both.
- DEPTH=200: write 0xAAAAAAAA to address 200 -> wr_error rises the next cycle and stays high, words 199 and 0 unchanged; read address 250 -> q=0 with q_valid.
- READ_LATENCY=2: rden every cycle for addresses 0..7, each preloaded with value = address -> q_valid continuous for 8 cycles starting 2 cycles after the first request, q = 0..7 in order.
- Reset asserted at INIT word 100 and held 1 cycle -> busy stays high a further 256 cycles; in-flight read in RUN cut by reset -> no q_valid emitted.

Source files
------------

// File: rtl/ram_sdp_param.sv
// Simple-dual-port RAM: per-bit masked write, 1- or 2-cycle pipelined read, optional zero-fill after reset.
// Latency READ_LATENCY cycles rden -> q/q_valid; no backpressure, requests are dropped while busy.
module ram_sdp_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic [DATA_WIDTH-1:0] wrmask,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  busy,
    output logic                  wr_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [ADDR_WIDTH-1:0] w_init_cnt_nxt;
    logic                  w_init_wr;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_run;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_do;
    logic                  w_rd_do;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  r_rd_vld;
    logic [DATA_WIDTH-1:0] r_rd_dat;
    logic                  r_wr_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_init_wr      = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_wr      = 1'b1;
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == LAST_WORD) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign busy          = (CLEAR_ON_RESET != 0) && (reset || (r_state == S_INIT));
    assign w_run         = (r_state == S_RUN) && !reset;
    assign w_wr_in_range = ({1'b0, wraddress} < DEPTH_EXT);
    assign w_rd_in_range = ({1'b0, rdaddress} < DEPTH_EXT);
    assign w_wr_do       = w_run && wren && w_wr_in_range;
    assign w_rd_do       = w_run && rden;
    assign w_wr_merged   = (r_mem[wraddress] & ~wrmask) | (data & wrmask);

    // Out-of-range reads return zero; same-address bypass forwards the merged word.
    always_comb begin
        w_rd_word = r_mem[rdaddress];
        if (!w_rd_in_range) begin
            w_rd_word = '0;
        end else if ((BYPASS != 0) && w_wr_do && (wraddress == rdaddress)) begin
            w_rd_word = w_wr_merged;
        end
    end

    always_ff @(posedge clock) begin
        if (w_init_wr && !reset) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr_do) begin
            r_mem[wraddress] <= w_wr_merged;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_vld   <= 1'b0;
            r_rd_dat   <= '0;
            r_wr_error <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_do;
            if (w_rd_do) begin
                r_rd_dat <= w_rd_word;
            end
            if (w_run && wren && !w_wr_in_range) begin
                r_wr_error <= 1'b1;
            end
        end
    end

    assign wr_error = r_wr_error;

    if (READ_LATENCY == 1) begin : g_lat1
        assign q       = r_rd_dat;
        assign q_valid = r_rd_vld;
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_out_vld;
        logic [DATA_WIDTH-1:0] r_out_dat;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_out_vld <= 1'b0;
                r_out_dat <= '0;
            end else begin
                r_out_vld <= r_rd_vld;
                if (r_rd_vld) begin
                    r_out_dat <= r_rd_dat;
                end
            end
        end

        assign q       = r_out_dat;
        assign q_valid = r_out_vld;
    end else begin : g_bad_latency
        $error("ram_sdp_param: READ_LATENCY must be 1 or 2");
        assign q       = '0;
        assign q_valid = 1'b0;
    end

endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench: DUT A uses defaults (256 words, latency 1, bypass); DUT B is 200 words, latency 2, no bypass.
module tb_ram_sdp_param;

    logic        clk;
    int          errors;
    int          checks;
    int          cnt;
    int          qv;

    logic        a_reset, a_wren, a_rden, a_q_valid, a_busy, a_wr_error;
    logic [31:0] a_data, a_wrmask, a_q;
    logic [7:0]  a_wraddress, a_rdaddress;

    logic        b_reset, b_wren, b_rden, b_q_valid, b_busy, b_wr_error;
    logic [31:0] b_data, b_wrmask, b_q;
    logic [7:0]  b_wraddress, b_rdaddress;

    ram_sdp_param u_a (
        .clock(clk), .reset(a_reset), .data(a_data), .wraddress(a_wraddress),
        .wrmask(a_wrmask), .wren(a_wren), .rdaddress(a_rdaddress), .rden(a_rden),
        .q(a_q), .q_valid(a_q_valid), .busy(a_busy), .wr_error(a_wr_error)
    );

    ram_sdp_param #(
        .DEPTH(200), .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) u_b (
        .clock(clk), .reset(b_reset), .data(b_data), .wraddress(b_wraddress),
        .wrmask(b_wrmask), .wren(b_wren), .rdaddress(b_rdaddress), .rden(b_rden),
        .q(b_q), .q_valid(b_q_valid), .busy(b_busy), .wr_error(b_wr_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        a_reset = 1'b1; a_wren = 1'b0; a_rden = 1'b0; a_data = '0; a_wrmask = '0;
        a_wraddress = '0; a_rdaddress = '0;
        b_reset = 1'b1; b_wren = 1'b0; b_rden = 1'b0; b_data = '0; b_wrmask = '0;
        b_wraddress = '0; b_rdaddress = '0;

        // Reset state of A
        @(negedge clk); #1;
        chk("a_rst_q", a_q, 32'h0);
        chk("a_rst_qv", {31'b0, a_q_valid}, 32'd0);
        chk("a_rst_err", {31'b0, a_wr_error}, 32'd0);
        chk("a_rst_busy", {31'b0, a_busy}, 32'd1);

        // INIT length with a read request held during INIT
        @(negedge clk);
        a_reset = 1'b0; a_rden = 1'b1; a_rdaddress = 8'h05;
        #1;
        cnt = 0; qv = 0;
        while (a_busy === 1'b1 && cnt < 400) begin
            if (a_q_valid !== 1'b0) qv++;
            cnt++;
            @(negedge clk); #1;
        end
        chk("a_init_len", 32'(cnt), 32'd256);
        chk("a_init_no_qv", 32'(qv), 32'd0);
        a_rdaddress = 8'hFF;
        @(negedge clk); a_rden = 1'b0; #1;
        chk("a_ff_qv", {31'b0, a_q_valid}, 32'd1);
        chk("a_ff_q", a_q, 32'h0);
        @(negedge clk); #1;
        chk("a_qv_pulse", {31'b0, a_q_valid}, 32'd0);

        // Masked write merge, then read with X on idle write inputs
        @(negedge clk); a_wren = 1'b1; a_wraddress = 8'h10; a_data = 32'hDEADBEEF; a_wrmask = 32'hFFFFFFFF;
        @(negedge clk); a_data = 32'h12345678; a_wrmask = 32'h0000FFFF;
        @(negedge clk); a_wren = 1'b0; a_data = 'x; a_wrmask = 'x; a_rden = 1'b1; a_rdaddress = 8'h10;
        @(negedge clk); a_rden = 1'b0; #1;
        chk("a_mask_merge", a_q, 32'hDEAD5678);

        // Bypass on A
        @(negedge clk); a_wren = 1'b1; a_wraddress = 8'h20; a_data = 32'h11111111; a_wrmask = 32'hFFFFFFFF;
        @(negedge clk); a_data = 32'h22222222; a_rden = 1'b1; a_rdaddress = 8'h20;
        @(negedge clk); a_wren = 1'b0; #1;
        chk("a_bypass_same", a_q, 32'h22222222);
        @(negedge clk); a_wren = 1'b1; a_wraddress = 8'h30; a_data = 32'h33333333; a_rdaddress = 8'h10; #1;
        chk("a_bypass_next", a_q, 32'h22222222);
        @(negedge clk); a_wren = 1'b0; a_rden = 1'b0; #1;
        chk("a_indep_rd", a_q, 32'hDEAD5678);
        @(negedge clk); #1;
        chk("a_hold_qv", {31'b0, a_q_valid}, 32'd0);
        chk("a_hold_q", a_q, 32'hDEAD5678);
        @(negedge clk); a_rden = 1'b1; a_rdaddress = 8'h30;
        @(negedge clk); a_rden = 1'b0; #1;
        chk("a_indep_wr", a_q, 32'h33333333);

        // Reset at INIT word 100 restarts the fill
        @(negedge clk); a_reset = 1'b1;
        @(negedge clk); a_reset = 1'b0;
        repeat (100) @(negedge clk);
        a_reset = 1'b1; #1;
        chk("a_busy_in_rst", {31'b0, a_busy}, 32'd1);
        @(negedge clk); a_reset = 1'b0; #1;
        cnt = 0;
        while (a_busy === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk); #1;
        end
        chk("a_reinit_len", 32'(cnt), 32'd256);
        a_rden = 1'b1; a_rdaddress = 8'h10;
        @(negedge clk); a_rden = 1'b0; #1;
        chk("a_cleared", a_q, 32'h0);

        // DUT B: 200-word INIT
        @(negedge clk); b_reset = 1'b0; #1;
        cnt = 0; qv = 0;
        while (b_busy === 1'b1 && cnt < 400) begin
            if (b_q_valid !== 1'b0) qv++;
            cnt++;
            @(negedge clk); #1;
        end
        chk("b_init_len", 32'(cnt), 32'd200);
        chk("b_init_no_qv", 32'(qv), 32'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk); b_wren = 1'b1; b_wraddress = 8'(i); b_data = 32'(i); b_wrmask = 32'hFFFFFFFF;
        end
        @(negedge clk); b_wraddress = 8'h20; b_data = 32'h11111111;
        @(negedge clk); b_wraddress = 8'd199; b_data = 32'hC0FFEE99;
        @(negedge clk); b_wraddress = 8'd200; b_data = 32'hAAAAAAAA; #1;
        chk("b_err_before", {31'b0, b_wr_error}, 32'd0);
        @(negedge clk); b_wren = 1'b0; #1;
        chk("b_err_set", {31'b0, b_wr_error}, 32'd1);

        // Reads 199, 250, 7, 0 back-to-back with latency 2
        @(negedge clk); b_rden = 1'b1; b_rdaddress = 8'd199;
        @(negedge clk); b_rdaddress = 8'd250; #1;
        chk("b_lat2_not_yet", {31'b0, b_q_valid}, 32'd0);
        @(negedge clk); b_rdaddress = 8'd7; #1;
        chk("b_word199", b_q, 32'hC0FFEE99);
        @(negedge clk); b_rdaddress = 8'd0; #1;
        chk("b_oor_rd_q", b_q, 32'h0);
        chk("b_oor_rd_qv", {31'b0, b_q_valid}, 32'd1);
        @(negedge clk); b_rden = 1'b0; #1;
        chk("b_word7", b_q, 32'h7);
        @(negedge clk); #1;
        chk("b_word0", b_q, 32'h0);
        chk("b_err_sticky", {31'b0, b_wr_error}, 32'd1);

        // Full-throughput pipelined reads of words 0..7
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            b_rden = (i < 8); b_rdaddress = 8'(i); #1;
            chk("b_pipe_qv", {31'b0, b_q_valid}, (i >= 2 && i < 10) ? 32'd1 : 32'd0);
            if (i >= 2 && i < 10) chk("b_pipe_q", b_q, 32'(i - 2));
        end

        // No bypass: same-cycle read returns old word, next-cycle read the new one
        @(negedge clk); b_wren = 1'b1; b_wraddress = 8'h20; b_data = 32'h22222222;
        b_rden = 1'b1; b_rdaddress = 8'h20;
        @(negedge clk); b_wren = 1'b0;
        @(negedge clk); b_rden = 1'b0; #1;
        chk("b_nobyp_same", b_q, 32'h11111111);
        @(negedge clk); #1;
        chk("b_nobyp_next", b_q, 32'h22222222);
        @(negedge clk); #1;
        chk("b_nobyp_qv_end", {31'b0, b_q_valid}, 32'd0);

        // Reset in RUN cuts an in-flight read
        @(negedge clk); b_rden = 1'b1; b_rdaddress = 8'd3;
        @(negedge clk); b_rden = 1'b0; b_reset = 1'b1; #1;
        chk("b_cut_qv0", {31'b0, b_q_valid}, 32'd0);
        chk("b_rst_busy", {31'b0, b_busy}, 32'd1);
        @(negedge clk); b_reset = 1'b0; #1;
        chk("b_cut_qv1", {31'b0, b_q_valid}, 32'd0);
        chk("b_rst_q", b_q, 32'h0);
        chk("b_rst_err", {31'b0, b_wr_error}, 32'd0);
        @(negedge clk); #1;
        chk("b_cut_qv2", {31'b0, b_q_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
